riscv_rf_wport_arbiter: RTL and testbench

//  Shares the two register-file write ports (W1 = port A, W2 = port B) among NUM_REQ

---
 rtl/riscv_rf_wport_arbiter.sv | 128 ++++++++++++
 tb/tb_riscv_rf_wport_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rf_wport_arbiter.sv
// rtl/riscv_rf_wport_arbiter.sv - round-robin arbiter sharing two register-file write ports
// Grants are chosen combinationally from a rotating scan and registered onto ports A and B.
module riscv_rf_wport_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_b_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic [(2**ADDR_WIDTH)-1:0]    pending_o
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_we_a;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_a;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_a;
  logic [DATA_WIDTH-1:0] r_wdata_b;

  logic [NUM_REQ-1:0] w_ready;
  logic               w_a_vld;
  logic               w_b_vld;
  logic [PTR_W-1:0]   w_a_idx;
  logic [PTR_W-1:0]   w_b_idx;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_last;
  logic [PTR_W-1:0]   w_next_ptr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr[i] = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_data[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Writes to x0 are acknowledged and discarded without taking a port.
  always_comb begin
    w_ready = '0;
    w_a_vld = 1'b0;
    w_b_vld = 1'b0;
    w_a_idx = '0;
    w_b_idx = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (req_valid_i[w_idx]) begin
        if (w_addr[w_idx] == '0) begin
          w_ready[w_idx] = 1'b1;
        end else if (!w_a_vld) begin
          w_a_vld        = 1'b1;
          w_a_idx        = w_idx;
          w_ready[w_idx] = 1'b1;
        end else if (!w_b_vld && (w_addr[w_idx] != w_addr[w_a_idx])) begin
          w_b_vld        = 1'b1;
          w_b_idx        = w_idx;
          w_ready[w_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_last     = w_b_vld ? w_b_idx : w_a_idx;
    w_next_ptr = (w_last == PTR_W'(NUM_REQ - 1)) ? '0 : w_last + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_we_a    <= 1'b0;
      r_we_b    <= 1'b0;
      r_waddr_a <= '0;
      r_waddr_b <= '0;
      r_wdata_a <= '0;
      r_wdata_b <= '0;
    end else begin
      r_we_a <= w_a_vld;
      r_we_b <= w_b_vld;
      if (w_a_vld) begin
        r_waddr_a <= w_addr[w_a_idx];
        r_wdata_a <= w_data[w_a_idx];
      end
      if (w_b_vld) begin
        r_waddr_b <= w_addr[w_b_idx];
        r_wdata_b <= w_data[w_b_idx];
      end
      if (w_a_vld) r_rr_ptr <= w_next_ptr;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_o[r] = (r_we_a && (r_waddr_a == ADDR_WIDTH'(r))) ||
                     (r_we_b && (r_waddr_b == ADDR_WIDTH'(r)));
    end
  end

  assign req_ready_o = w_ready;
  assign we_a_o      = r_we_a;
  assign waddr_a_o   = r_waddr_a;
  assign wdata_a_o   = r_wdata_a;
  assign we_b_o      = r_we_b;
  assign waddr_b_o   = r_waddr_b;
  assign wdata_b_o   = r_wdata_b;

endmodule

// File: tb/tb_riscv_rf_wport_arbiter.sv
// tb/tb_riscv_rf_wport_arbiter.sv - bench for riscv_rf_wport_arbiter
// Reference model of the two-port writeback arbiter plus directed scenarios.
module tb_riscv_rf_wport_arbiter;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid_i;
  logic [AW-1:0]   addr [NR];
  logic [DW-1:0]   data [NR];
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]   req_ready_o;
  logic            we_a_o, we_b_o;
  logic [AW-1:0]   waddr_a_o, waddr_b_o;
  logic [DW-1:0]   wdata_a_o, wdata_b_o;
  logic [31:0]     pending_o;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  assign req_addr_i = {addr[2], addr[1], addr[0]};
  assign req_data_i = {data[2], data[1], data[0]};

  riscv_rf_wport_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan requesters from ptr, x0 writes acked for free, two distinct-address winners.
  function automatic void grant(input int ptr, input logic [NR-1:0] v, input logic [NR*AW-1:0] fa,
                                output logic [NR-1:0] rdy, output bit a_ok, output int a_i,
                                output bit b_ok, output int b_i);
    rdy = '0; a_ok = 0; b_ok = 0; a_i = 0; b_i = 0;
    for (int k = 0; k < NR; k++) begin
      int i;
      int ad;
      i  = (ptr + k) % NR;
      ad = int'(fa[i*AW +: AW]);
      if (v[i]) begin
        if (ad == 0) rdy[i] = 1'b1;
        else if (!a_ok) begin a_ok = 1; a_i = i; rdy[i] = 1'b1; end
        else if (!b_ok && ad != int'(fa[a_i*AW +: AW])) begin b_ok = 1; b_i = i; rdy[i] = 1'b1; end
      end
    end
  endfunction

  int m_ptr;
  bit m_we_a, m_we_b;
  logic [AW-1:0] m_addr_a, m_addr_b;
  logic [DW-1:0] m_data_a, m_data_b;
  logic [NR-1:0] g_rdy;
  bit g_a_ok, g_b_ok;
  int g_a_i, g_b_i;
  logic [31:0] m_pending;

  always_comb grant(m_ptr, req_valid_i, req_addr_i, g_rdy, g_a_ok, g_a_i, g_b_ok, g_b_i);

  always_comb begin
    m_pending = 32'd0;
    if (m_we_a) m_pending = m_pending | (32'd1 << m_addr_a);
    if (m_we_b) m_pending = m_pending | (32'd1 << m_addr_b);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_we_a <= 0; m_we_b <= 0;
      m_addr_a <= '0; m_addr_b <= '0; m_data_a <= '0; m_data_b <= '0;
    end else begin
      m_we_a <= g_a_ok;
      m_we_b <= g_b_ok;
      if (g_a_ok) begin m_addr_a <= addr[g_a_i]; m_data_a <= data[g_a_i]; end
      if (g_b_ok) begin m_addr_b <= addr[g_b_i]; m_data_b <= data[g_b_i]; end
      if (g_b_ok) m_ptr <= (g_b_i + 1) % NR;
      else if (g_a_ok) m_ptr <= (g_a_i + 1) % NR;
    end
  end

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      chk("m_ready", req_ready_o, g_rdy);
      chk("m_we_a", we_a_o, m_we_a);
      chk("m_we_b", we_b_o, m_we_b);
      chk("m_waddr_a", waddr_a_o, m_addr_a);
      chk("m_wdata_a", wdata_a_o, m_data_a);
      chk("m_waddr_b", waddr_b_o, m_addr_b);
      chk("m_wdata_b", wdata_b_o, m_data_b);
      chk("m_pending", pending_o, m_pending);
      if (we_a_o && we_b_o) chk("m_ports_distinct", waddr_a_o != waddr_b_o, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v);
    req_valid_i = v;
  endtask

  int cnt [NR];
  int gap [NR];
  int maxgap;

  initial begin
    rst_n = 1'b0;
    req_valid_i = '0;
    for (int i = 0; i < NR; i++) begin addr[i] = '0; data[i] = '0; end
    tick(); tick();
    rst_n = 1'b1;
    check_en = 1'b1;

    // single request on A
    addr[0] = 5'd5; data[0] = 32'hDEADBEEF; drive(3'b001);
    #2 chk("t2_ready", req_ready_o, 3'b001);
    tick(); drive(3'b000);
    chk("t2_we_a", we_a_o, 1); chk("t2_waddr_a", waddr_a_o, 5);
    chk("t2_wdata_a", wdata_a_o, 32'hDEADBEEF); chk("t2_we_b", we_b_o, 0);
    chk("t2_pending", pending_o, 32'h20);

    // async reset while outputs are active
    #2 rst_n = 1'b0;
    #1 chk("t1_we_a", we_a_o, 0); chk("t1_we_b", we_b_o, 0);
    chk("t1_pending", pending_o, 0); chk("t1_waddr_a", waddr_a_o, 0);
    chk("t1_wdata_a", wdata_a_o, 0);
    tick(); rst_n = 1'b1;

    // three requesters from ptr 0
    addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
    data[0] = 32'hA1; data[1] = 32'hA2; data[2] = 32'hA3;
    drive(3'b111);
    #2 chk("t3_ready", req_ready_o, 3'b011);
    tick(); drive(3'b100);
    chk("t3_waddr_a", waddr_a_o, 1); chk("t3_we_b", we_b_o, 1); chk("t3_waddr_b", waddr_b_o, 2);
    #2 chk("t3_ready2", req_ready_o, 3'b100);
    tick(); drive(3'b000);
    chk("t3_waddr_a2", waddr_a_o, 3); chk("t3_wdata_a2", wdata_a_o, 32'hA3); chk("t3_we_b2", we_b_o, 0);

    // same address: only one port per register
    addr[0] = 5'd7; addr[1] = 5'd7; data[0] = 32'h11; data[1] = 32'h22;
    drive(3'b011);
    #2 chk("t4_ready", req_ready_o, 3'b001);
    tick(); drive(3'b010);
    chk("t4_waddr_a", waddr_a_o, 7); chk("t4_wdata_a", wdata_a_o, 32'h11); chk("t4_we_b", we_b_o, 0);
    #2 chk("t4_ready2", req_ready_o, 3'b010);
    tick(); drive(3'b000);
    chk("t4_wdata_a2", wdata_a_o, 32'h22); chk("t4_we_b2", we_b_o, 0);

    // x0 drop alongside a real write, pointer wraps from 2
    addr[1] = 5'd0; addr[2] = 5'd4; data[1] = 32'h55; data[2] = 32'h44;
    drive(3'b110);
    #2 chk("t5_ready", req_ready_o, 3'b110);
    tick(); drive(3'b000);
    chk("t5_we_a", we_a_o, 1); chk("t5_waddr_a", waddr_a_o, 4);
    chk("t5_we_b", we_b_o, 0); chk("t5_pending", pending_o, 32'h10);
    tick();
    chk("t5_idle_we_a", we_a_o, 0); chk("t5_hold_waddr_a", waddr_a_o, 4);
    addr[0] = 5'd9; addr[2] = 5'd10; data[0] = 32'h99; data[2] = 32'h1010;
    drive(3'b101);
    #2 chk("t5_ready_ptr0", req_ready_o, 3'b101);
    tick(); drive(3'b000);
    chk("t5_waddr_a_ptr0", waddr_a_o, 9); chk("t5_waddr_b_ptr0", waddr_b_o, 10);

    // fairness with all requesters continuously valid
    addr[0] = 5'd11; addr[1] = 5'd12; addr[2] = 5'd13;
    data[0] = 32'hB0; data[1] = 32'hB1; data[2] = 32'hB2;
    for (int i = 0; i < NR; i++) begin cnt[i] = 0; gap[i] = 0; end
    maxgap = 0;
    drive(3'b111);
    for (int c = 0; c < 12; c++) begin
      #2;
      for (int i = 0; i < NR; i++) begin
        if (req_ready_o[i]) begin cnt[i]++; gap[i] = 0; end
        else begin gap[i]++; if (gap[i] > maxgap) maxgap = gap[i]; end
      end
      tick();
    end
    drive(3'b000);
    for (int i = 0; i < NR; i++) chk("t6_count_ge8", cnt[i] >= 8, 1);
    chk("t6_maxgap", maxgap <= NR - 1, 1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
